// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : UART receive path. Oversamples the rx line with the shared
//               baud tick, deserialises start + WORD_BITS data (LSB first) +
//               stop, and reports each frame with a one-cycle done strobe and
//               a framing-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int WORD_BITS    = 8,   // data bits per frame (>= 2)
    parameter int SAMPLE_TICKS = 16   // baud ticks per bit period, even, >= 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rx_i,
    input  logic                 baud_i,
    output logic [WORD_BITS-1:0] data_o,
    output logic                 rx_done_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int c_S_W = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
    localparam int c_N_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

    // Tick counts at which the middle of a start bit / data or stop bit is reached.
    localparam logic [c_S_W-1:0] c_S_HALF = c_S_W'(SAMPLE_TICKS / 2 - 1);
    localparam logic [c_S_W-1:0] c_S_LAST = c_S_W'(SAMPLE_TICKS - 1);
    localparam logic [c_N_W-1:0] c_N_LAST = c_N_W'(WORD_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_prev;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_S_W-1:0]     r_s;
    logic [c_S_W-1:0]     w_s_next;
    logic [c_N_W-1:0]     r_n;
    logic [c_N_W-1:0]     w_n_next;
    logic [WORD_BITS-1:0] r_sh;
    logic [WORD_BITS-1:0] w_sh_next;
    logic [WORD_BITS-1:0] r_data;
    logic [WORD_BITS-1:0] w_data_next;
    logic                 r_done;
    logic                 w_done_next;
    logic                 r_ferr;
    logic                 w_ferr_next;

    // Two-flop synchroniser for the asynchronous line plus one delay stage for edge detect.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_sh    <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_sh    <= w_sh_next;
            r_data  <= w_data_next;
            r_done  <= w_done_next;
            r_ferr  <= w_ferr_next;
        end
    end

    // Next-state logic: everything except the idle edge detect advances on baud ticks only.
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_sh_next    = r_sh;
        w_data_next  = r_data;
        w_ferr_next  = r_ferr;
        w_done_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Edge rather than level, so a line held low cannot retrigger.
                // A tick coinciding with the edge is deliberately not counted.
                if (r_rx_prev && !r_rx_s) begin
                    w_state_next = S_START;
                    w_s_next     = '0;
                end
            end
            S_START: begin
                if (baud_i) begin
                    if (r_s == c_S_HALF) begin
                        if (!r_rx_s) begin
                            w_state_next = S_DATA;
                            w_s_next     = '0;
                            w_n_next     = '0;
                        end else begin
                            // Line back high by mid start bit: glitch, drop silently.
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (baud_i) begin
                    if (r_s == c_S_LAST) begin
                        w_s_next  = '0;
                        w_sh_next = {r_rx_s, r_sh[WORD_BITS-1:1]};
                        if (r_n == c_N_LAST) begin
                            w_state_next = S_STOP;
                        end else begin
                            w_n_next = r_n + 1'b1;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (baud_i) begin
                    if (r_s == c_S_LAST) begin
                        // Bad stop bits are still delivered, just flagged.
                        w_data_next  = r_sh;
                        w_ferr_next  = ~r_rx_s;
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign data_o      = r_data;
    assign rx_done_o   = r_done;
    assign frame_err_o = r_ferr;
    assign busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire
